// File: rtl/uart_pi_pkg.sv
// Shared definitions for the UART-to-processor-interface bridge:
// FSM state encodings, command byte field positions and the write ACK byte.
package uart_pi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_DATA = 3'd1;
  localparam state_t ST_WRITE     = 3'd2;
  localparam state_t ST_READ      = 3'd3;
  localparam state_t ST_SEND      = 3'd4;

  // Command byte layout: [7] write/read, [6:4] block index, [3:0] register address.
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_BLK_MSB  = 6;
  localparam int CMD_BLK_LSB  = 4;
  localparam int CMD_ADDR_MSB = 3;

  localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/pi_timeout_ctr.sv
// Saturating cycle counter guarding the gap between a write command and its
// data byte. 'expired' is a registered one-cycle pulse issued on the cycle the
// count reaches TIMEOUT; it is not repeated while the count stays saturated.
module pi_timeout_ctr #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Count enabled cycles up to LIMIT and flag the step that lands on it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt_r   <= '0;
      expired <= 1'b0;
    end else if (en) begin
      if (cnt_r != LIMIT) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      expired <= (cnt_r == LAST);
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_pi_bridge.sv
// UART command bridge: decodes received command bytes into single-cycle pi
// read/write strobes with one-hot block select, returns read data (or a write
// ACK) to the UART transmitter, and reports dropped bytes and abandoned writes.
module uart_pi_bridge
  import uart_pi_pkg::*;
#(
  parameter int NUM_BLK = 8,
  parameter int TIMEOUT = 1_000_000,
  parameter int WR_ACK  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_BLK-1:0]   pi_blk_sel,
  output logic [3:0]           pi_addr,
  output logic                 pi_wr_en,
  output logic                 pi_rd_en,
  output logic [7:0]           pi_wr_data,
  input  logic [8*NUM_BLK-1:0] pi_rd_data_bus,
  output logic                 rx_drop,
  output logic                 timeout_err
);

  state_t     state_r;
  logic [2:0] blk_r;
  logic [3:0] addr_r;

  logic [2:0] cmd_blk_s;
  logic [3:0] cmd_addr_s;
  logic       tmo_clr_s;
  logic       tmo_en_s;
  logic [7:0] rd_slice_s;

  // One-hot select for a block index; unmapped indices give all-zero.
  function automatic logic [NUM_BLK-1:0] blk_onehot(input logic [2:0] idx);
    logic [NUM_BLK-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_BLK; k++) begin
      if (idx == 3'(k)) begin
        oh[k] = 1'b1;
      end else begin
        oh[k] = 1'b0;
      end
    end
    return oh;
  endfunction

  // True when the block index addresses an existing slave.
  function automatic logic blk_mapped(input logic [2:0] idx);
    return ({1'b0, idx} < 4'(NUM_BLK));
  endfunction

  assign cmd_blk_s  = rx_data[CMD_BLK_MSB:CMD_BLK_LSB];
  assign cmd_addr_s = rx_data[CMD_ADDR_MSB:0];

  // The counter restarts on every accepted write command and only advances
  // while waiting with no byte arriving, so a data byte on the last allowed
  // cycle never coincides with a timeout pulse.
  assign tmo_clr_s = (state_r == ST_IDLE) && rx_valid && rx_data[CMD_WR_BIT];
  assign tmo_en_s  = (state_r == ST_WAIT_DATA) && !rx_valid;

  pi_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (timeout_err)
  );

  // Select the read-data slice of the latched block; unmapped blocks read 0x00.
  always_comb begin
    rd_slice_s = 8'h00;
    for (int k = 0; k < NUM_BLK; k++) begin
      if (blk_r == 3'(k)) begin
        rd_slice_s = pi_rd_data_bus[8*k +: 8];
      end else begin
        rd_slice_s = rd_slice_s;
      end
    end
  end

  // Command FSM with registered pi strobes, tx handshake and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      blk_r      <= 3'd0;
      addr_r     <= 4'd0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      pi_blk_sel <= '0;
      pi_addr    <= 4'd0;
      pi_wr_en   <= 1'b0;
      pi_rd_en   <= 1'b0;
      pi_wr_data <= 8'h00;
      rx_drop    <= 1'b0;
    end else begin
      pi_wr_en   <= 1'b0;
      pi_rd_en   <= 1'b0;
      pi_blk_sel <= '0;
      rx_drop    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_valid) begin
            blk_r  <= cmd_blk_s;
            addr_r <= cmd_addr_s;
            if (rx_data[CMD_WR_BIT]) begin
              state_r <= ST_WAIT_DATA;
            end else begin
              // Read strobe is launched here so it is live during READ.
              state_r <= ST_READ;
              if (blk_mapped(cmd_blk_s)) begin
                pi_rd_en   <= 1'b1;
                pi_blk_sel <= blk_onehot(cmd_blk_s);
                pi_addr    <= cmd_addr_s;
              end
            end
          end
        end
        ST_WAIT_DATA: begin
          if (timeout_err) begin
            // Abandon the write; a byte racing the timeout is discarded.
            state_r <= ST_IDLE;
            rx_drop <= rx_valid;
          end else if (rx_valid) begin
            state_r    <= ST_WRITE;
            pi_wr_data <= rx_data;
            if (blk_mapped(blk_r)) begin
              pi_wr_en   <= 1'b1;
              pi_blk_sel <= blk_onehot(blk_r);
              pi_addr    <= addr_r;
            end
          end
        end
        ST_WRITE: begin
          rx_drop <= rx_valid;
          if (WR_ACK != 0) begin
            tx_data  <= ACK_BYTE;
            tx_valid <= 1'b1;
            state_r  <= ST_SEND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          // Capture read data on the strobe edge; later slave changes are ignored.
          rx_drop  <= rx_valid;
          tx_data  <= rd_slice_s;
          tx_valid <= 1'b1;
          state_r  <= ST_SEND;
        end
        ST_SEND: begin
          rx_drop <= rx_valid;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pi_bridge.sv
// Directed scoreboard bench for uart_pi_bridge. DUT A: 8 blocks, TIMEOUT=16.
// DUT B: 4 blocks, used for unmapped-block behaviour.
module tb_uart_pi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        a_rx_valid;
  logic        b_rx_valid;
  logic        tx_ready;

  logic [7:0]  a_tx_data;
  logic        a_tx_valid;
  logic [7:0]  a_pi_blk_sel;
  logic [3:0]  a_pi_addr;
  logic        a_pi_wr_en;
  logic        a_pi_rd_en;
  logic [7:0]  a_pi_wr_data;
  logic [63:0] a_rd_bus;
  logic        a_rx_drop;
  logic        a_timeout_err;

  logic [7:0]  b_tx_data;
  logic        b_tx_valid;
  logic [3:0]  b_pi_blk_sel;
  logic [3:0]  b_pi_addr;
  logic        b_pi_wr_en;
  logic        b_pi_rd_en;
  logic [7:0]  b_pi_wr_data;
  logic [31:0] b_rd_bus;
  logic        b_rx_drop;
  logic        b_timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int drop_cnt = 0;
  int tmo_cnt  = 0;
  int b_wr_cnt = 0;
  int b_rd_cnt = 0;
  int d0;
  bit mon_en = 1'b0;

  logic [19:0] exp_wr_q[$];  // {blk_sel, addr, wr_data}
  logic [11:0] exp_rd_q[$];  // {blk_sel, addr}
  logic [7:0]  exp_tx_q[$];

  always #5 clk = ~clk;

  uart_pi_bridge #(.NUM_BLK(8), .TIMEOUT(16), .WR_ACK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(a_rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .pi_blk_sel(a_pi_blk_sel), .pi_addr(a_pi_addr), .pi_wr_en(a_pi_wr_en),
    .pi_rd_en(a_pi_rd_en), .pi_wr_data(a_pi_wr_data), .pi_rd_data_bus(a_rd_bus),
    .rx_drop(a_rx_drop), .timeout_err(a_timeout_err)
  );

  uart_pi_bridge #(.NUM_BLK(4), .TIMEOUT(16), .WR_ACK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(b_rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .pi_blk_sel(b_pi_blk_sel), .pi_addr(b_pi_addr), .pi_wr_en(b_pi_wr_en),
    .pi_rd_en(b_pi_rd_en), .pi_wr_data(b_pi_wr_data), .pi_rd_data_bus(b_rd_bus),
    .rx_drop(b_rx_drop), .timeout_err(b_timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    rx_data = b;
    a_rx_valid = 1'b1;
    step();
    a_rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_data = b;
    b_rx_valid = 1'b1;
    step();
    b_rx_valid = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_tx_data"}, a_tx_data, 8'h00);
    check({tag, "_tx_valid"}, a_tx_valid, 1'b0);
    check({tag, "_blk_sel"}, a_pi_blk_sel, 8'h00);
    check({tag, "_addr"}, a_pi_addr, 4'h0);
    check({tag, "_wr_en"}, a_pi_wr_en, 1'b0);
    check({tag, "_rd_en"}, a_pi_rd_en, 1'b0);
    check({tag, "_wr_data"}, a_pi_wr_data, 8'h00);
    check({tag, "_rx_drop"}, a_rx_drop, 1'b0);
    check({tag, "_timeout_err"}, a_timeout_err, 1'b0);
  endtask

  // Scoreboard monitor for DUT A, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_pi_wr_en) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected_pending", 64'(exp_wr_q.size()), 64'd1);
        else check("wr_fields", {a_pi_blk_sel, a_pi_addr, a_pi_wr_data}, exp_wr_q.pop_front());
      end
      if (a_pi_rd_en) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected_pending", 64'(exp_rd_q.size()), 64'd1);
        else check("rd_fields", {a_pi_blk_sel, a_pi_addr}, exp_rd_q.pop_front());
      end
      if (!a_pi_wr_en && !a_pi_rd_en) check("blk_sel_idle", a_pi_blk_sel, 8'h00);
      if (a_tx_valid) begin
        if (exp_tx_q.size() == 0) check("tx_unexpected_pending", 64'(exp_tx_q.size()), 64'd1);
        else begin
          check("tx_data", a_tx_data, exp_tx_q[0]);
          if (tx_ready) void'(exp_tx_q.pop_front());
        end
      end
      if (a_rx_drop) drop_cnt++;
      if (a_timeout_err) tmo_cnt++;
    end
  end

  // Strobe counters for DUT B.
  always @(negedge clk) begin
    if (mon_en) begin
      if (b_pi_wr_en) b_wr_cnt++;
      if (b_pi_rd_en) b_rd_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    a_rx_valid = 1'b0;
    b_rx_valid = 1'b0;
    tx_ready = 1'b1;
    a_rd_bus = 64'h0807_0605_0403_0201;
    a_rd_bus[15:8] = 8'h05;
    b_rd_bus = 32'hFFFF_FFFF;
    repeat (3) step();
    check_reset_a("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Write 0x91, 0x2C with ACK held until tx_ready.
    tx_ready = 1'b0;
    exp_wr_q.push_back({8'b0000_0010, 4'h1, 8'h2C});
    exp_tx_q.push_back(8'hA5);
    send_a(8'h91);
    check("wr_no_early_strobe", a_pi_wr_en, 1'b0);
    send_a(8'h2C);
    check("wr_strobe_m1", a_pi_wr_en, 1'b1);
    step();
    check("wr_strobe_single", a_pi_wr_en, 1'b0);
    check("wr_ack_valid_m2", a_tx_valid, 1'b1);
    check("wr_data_hold", a_pi_wr_data, 8'h2C);
    repeat (3) step();
    check("wr_ack_held", a_tx_valid, 1'b1);
    tx_ready = 1'b1;
    step();
    check("wr_ack_done", a_tx_valid, 1'b0);

    // Read 0x10, slice changes after the strobe, back-to-back read follows.
    exp_rd_q.push_back({8'b0000_0010, 4'h0});
    exp_tx_q.push_back(8'h05);
    send_a(8'h10);
    check("rd_strobe_n1", a_pi_rd_en, 1'b1);
    step();
    check("rd_strobe_single", a_pi_rd_en, 1'b0);
    check("rd_valid_n2", a_tx_valid, 1'b1);
    a_rd_bus[15:8] = 8'h77;
    step();
    check("rd_done", a_tx_valid, 1'b0);
    a_rd_bus[31:24] = 8'h3C;
    exp_rd_q.push_back({8'b0000_1000, 4'h5});
    exp_tx_q.push_back(8'h3C);
    send_a(8'h35);
    check("rd_b2b_strobe", a_pi_rd_en, 1'b1);
    repeat (2) step();

    // Write timeout, then a normal read.
    send_a(8'hA3);
    repeat (15) step();
    check("tmo_not_early", a_timeout_err, 1'b0);
    step();
    check("tmo_pulse", a_timeout_err, 1'b1);
    check("tmo_no_wr", a_pi_wr_en, 1'b0);
    step();
    check("tmo_pulse_single", a_timeout_err, 1'b0);
    a_rd_bus[7:0] = 8'hC3;
    exp_rd_q.push_back({8'b0000_0001, 4'h0});
    exp_tx_q.push_back(8'hC3);
    send_a(8'h00);
    check("tmo_next_rd", a_pi_rd_en, 1'b1);
    repeat (2) step();

    // Stall in SEND with two injected bytes.
    tx_ready = 1'b0;
    exp_rd_q.push_back({8'b0000_0010, 4'h7});
    exp_tx_q.push_back(8'h77);
    send_a(8'h17);
    step();
    d0 = drop_cnt;
    step();
    send_a(8'h80);
    repeat (2) step();
    send_a(8'h22);
    repeat (3) step();
    check("stall_valid_held", a_tx_valid, 1'b1);
    tx_ready = 1'b1;
    repeat (2) step();
    check("stall_drops", 64'(drop_cnt - d0), 64'd2);

    // Reset inside WAIT_DATA; next byte is a command.
    send_a(8'h91);
    rst_n = 1'b0;
    step();
    check_reset_a("rst_wait");
    rst_n = 1'b1;
    exp_rd_q.push_back({8'b0000_0010, 4'h0});
    exp_tx_q.push_back(8'h77);
    send_a(8'h10);
    check("rst_wait_cmd", a_pi_rd_en, 1'b1);
    repeat (3) step();

    // Reset inside SEND; pending byte is lost.
    tx_ready = 1'b0;
    exp_rd_q.push_back({8'b0000_0010, 4'h0});
    exp_tx_q.push_back(8'h77);
    send_a(8'h10);
    step();
    rst_n = 1'b0;
    step();
    exp_tx_q.delete();
    check_reset_a("rst_send");
    rst_n = 1'b1;
    tx_ready = 1'b1;
    a_rd_bus[23:16] = 8'h5A;
    exp_rd_q.push_back({8'b0000_0100, 4'hC});
    exp_tx_q.push_back(8'h5A);
    send_a(8'h2C);
    check("rst_send_cmd", a_pi_rd_en, 1'b1);
    repeat (3) step();

    // DUT B: unmapped read and write, then last mapped block.
    send_b(8'h60);
    check("unm_rd_no_strobe", b_pi_rd_en, 1'b0);
    step();
    check("unm_rd_valid", b_tx_valid, 1'b1);
    check("unm_rd_data", b_tx_data, 8'h00);
    step();
    send_b(8'hE0);
    send_b(8'h11);
    check("unm_wr_no_strobe", b_pi_wr_en, 1'b0);
    step();
    check("unm_wr_ack_valid", b_tx_valid, 1'b1);
    check("unm_wr_ack_data", b_tx_data, 8'hA5);
    step();
    b_rd_bus[31:24] = 8'h4E;
    send_b(8'h32);
    check("b_blk3_strobe", b_pi_rd_en, 1'b1);
    check("b_blk3_sel", b_pi_blk_sel, 4'b1000);
    step();
    check("b_blk3_data", b_tx_data, 8'h4E);
    repeat (2) step();

    check("final_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    check("final_rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    check("final_tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
    check("final_tmo_cnt", 64'(tmo_cnt), 64'd1);
    check("final_drop_cnt", 64'(drop_cnt), 64'd2);
    check("final_b_wr_cnt", 64'(b_wr_cnt), 64'd0);
    check("final_b_rd_cnt", 64'(b_rd_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
